// File: rtl/sr_pkg.sv
// Shared types and constants for the SR latch driver.
package sr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CHECK
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  localparam int TIMER_W = 4;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that times the SETUP and PULSE phases of the latch driver.
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  // A load of N gives N+1 cycles before zero is seen, so callers load duration-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives an external enabled SR latch through setup, enable pulse and hold, then reads it back.
// Define SR_READBACK_CHECK_EN to compare lat_q/lat_qn against the written value and retry on mismatch.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int MAX_RETRY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_op,
  output logic req_ready,
  output logic lat_s,
  output logic lat_r,
  output logic lat_en,
  input  logic lat_q,
  input  logic lat_qn,
  output logic done,
  output logic err
);

  localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYC - 1);

  state_t state, state_n;
  logic   op, op_n;
  logic   s_n, r_n, en_n, done_n;
  logic   load;
  logic [TIMER_W-1:0] load_val;
  logic   zero;

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

`ifdef SR_READBACK_CHECK_EN
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  logic [2:0] retry, retry_n;
  logic       err_n;
  logic       readback_ok;

  // The forbidden Q == QN state can never match either expected pair.
  assign readback_ok = (op == OP_SET) ? (lat_q & ~lat_qn) : (~lat_q & lat_qn);

  always_ff @(posedge clk) begin
    if (rst) begin
      retry <= '0;
      err   <= 1'b0;
    end else begin
      retry <= retry_n;
      err   <= err_n;
    end
  end
`else
  localparam int unused_max_retry = MAX_RETRY;
  logic unused_readback;

  assign unused_readback = lat_q ^ lat_qn;
  assign err = 1'b0;
`endif

  assign req_ready = (state == ST_IDLE);

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    state_n  = state;
    op_n     = op;
    load     = 1'b0;
    load_val = '0;
    s_n      = 1'b0;
    r_n      = 1'b0;
    en_n     = 1'b0;
    done_n   = 1'b0;
`ifdef SR_READBACK_CHECK_EN
    retry_n  = retry;
    err_n    = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_n  = ST_SETUP;
          op_n     = req_op;
          load     = 1'b1;
          load_val = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (zero) begin
          state_n  = ST_PULSE;
          load     = 1'b1;
          load_val = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (zero) begin
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_n = ST_CHECK;
`ifdef SR_READBACK_CHECK_EN
        // The verdict is registered so done/err line up with the CHECK cycle.
        if (readback_ok) begin
          done_n  = 1'b1;
          retry_n = '0;
        end else if (retry < RETRY_MAX) begin
          retry_n = retry + 3'd1;
        end else begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          retry_n = '0;
        end
`else
        done_n = 1'b1;
`endif
      end
      ST_CHECK: begin
        if (done) begin
          state_n = ST_IDLE;
        end else begin
          state_n  = ST_SETUP;
          load     = 1'b1;
          load_val = SETUP_LOAD;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (state_n inside {ST_SETUP, ST_PULSE, ST_HOLD}) begin
      s_n = op_n;
      r_n = ~op_n;
    end
    en_n = (state_n == ST_PULSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op     <= OP_RESET;
      lat_s  <= 1'b0;
      lat_r  <= 1'b0;
      lat_en <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      op     <= op_n;
      lat_s  <= s_n;
      lat_r  <= r_n;
      lat_en <= en_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: directed latency cases plus randomized traffic
// checked every cycle against a schedule-based model of the request timeline.
module tb_sr_latch_driver;

  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 3;
  localparam int MAX_RETRY = 1;
  localparam int ATT_LEN   = SETUP_CYC + PULSE_CYC + 2;
`ifdef SR_READBACK_CHECK_EN
  localparam bit CHECKED = 1'b1;
`else
  localparam bit CHECKED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_op = 1'b0;
  logic req_ready, lat_s, lat_r, lat_en, done, err;
  logic lat_q, lat_qn;

  int tests_run = 0;
  int tests_failed = 0;
  int fail_prints = 0;

  always #5 clk = ~clk;

  sr_latch_driver #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .lat_s     (lat_s),
    .lat_r     (lat_r),
    .lat_en    (lat_en),
    .lat_q     (lat_q),
    .lat_qn    (lat_qn),
    .done      (done),
    .err       (err)
  );

  // External latch: 0 working, 1 stuck Q=1, 2 stuck Q=0, 3 forbidden 1/1, 4 disconnected 0/0.
  int   mode = 0;
  logic ql = 1'b0;

  always @(lat_en or lat_s or lat_r) begin
    if (lat_en) begin
      if (lat_s && !lat_r) ql = 1'b1;
      else if (lat_r && !lat_s) ql = 1'b0;
    end
  end

  always_comb begin
    case (mode)
      1:       begin lat_q = 1'b1; lat_qn = 1'b0; end
      2:       begin lat_q = 1'b0; lat_qn = 1'b1; end
      3:       begin lat_q = 1'b1; lat_qn = 1'b1; end
      4:       begin lat_q = 1'b0; lat_qn = 1'b0; end
      default: begin lat_q = ql;   lat_qn = ~ql;   end
    endcase
  end

  // Request timeline model: a request occupies m_att attempts of ATT_LEN cycles from its accept edge.
  int ecount = 0;
  bit m_active = 1'b0;
  int m_acc = 0;
  int m_att = 1;
  bit m_op = 1'b0;
  bit m_fail = 1'b0;
  int acc_count = 0;

  function automatic bit model_idle();
    return !m_active || ((ecount - m_acc) >= m_att * ATT_LEN);
  endfunction

  function automatic bit attempt_passes(input int m, input bit op);
    if (!CHECKED) return 1'b1;
    case (m)
      0:       return 1'b1;
      1:       return op == 1'b1;
      2:       return op == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit idle;
    idle = model_idle();
    ecount++;
    if (rst) begin
      m_active = 1'b0;
    end else if (idle && req_valid) begin
      m_active = 1'b1;
      m_acc    = ecount;
      m_op     = req_op;
      if (attempt_passes(mode, req_op)) begin
        m_att  = 1;
        m_fail = 1'b0;
      end else begin
        m_att  = MAX_RETRY + 1;
        m_fail = 1'b1;
      end
      acc_count++;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, ecount, act, exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic op, input int m, input logic valid);
    mode      = m;
    req_op    = op;
    req_valid = valid;
  endtask

  // Per-cycle comparison of every output against the model's timeline.
  always @(negedge clk) begin
    int j, a, o;
    logic e_rdy, e_s, e_r, e_en, e_done, e_err;
    if (ecount > 0) begin
      e_rdy = 1'b1; e_s = 1'b0; e_r = 1'b0; e_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
      j = ecount - m_acc;
      if (m_active && j < m_att * ATT_LEN) begin
        e_rdy = 1'b0;
        a = j / ATT_LEN;
        o = j % ATT_LEN;
        if (o < SETUP_CYC + PULSE_CYC + 1) begin
          e_s  = m_op;
          e_r  = !m_op;
          e_en = (o >= SETUP_CYC) && (o < SETUP_CYC + PULSE_CYC);
        end else begin
          e_done = (a == m_att - 1);
          e_err  = e_done && m_fail;
        end
      end
      checkOutput("req_ready", int'(req_ready), int'(e_rdy));
      checkOutput("lat_s", int'(lat_s), int'(e_s));
      checkOutput("lat_r", int'(lat_r), int'(e_r));
      checkOutput("lat_en", int'(lat_en), int'(e_en));
      checkOutput("done", int'(done), int'(e_done));
      checkOutput("err", int'(err), int'(e_err));
      checkOutput("s_r_exclusive", int'(lat_s & lat_r), 0);
    end
  end

  task automatic waitIdle();
    int waited;
    waited = 0;
    while (!model_idle() && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("idle_timeout", int'(model_idle()), 1);
  endtask

  task automatic runDirected(input string name, input logic op, input int m,
                             input int exp_done, input int exp_err, input int exp_pulses);
    int start_cnt, pulses, seen_at, seen_err;
    logic prev_en;
    bit seen;
    waitIdle();
    start_cnt = acc_count;
    applyStimulus(op, m, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput({name, "_accepted"}, acc_count - start_cnt, 1);
    checkOutput({name, "_model_latency"}, m_att * ATT_LEN, exp_done);
    seen = 1'b0; pulses = 0; prev_en = 1'b0; seen_at = -1; seen_err = -1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      if (lat_en && !prev_en) pulses++;
      prev_en = lat_en;
      if (done) begin
        seen     = 1'b1;
        seen_at  = k;
        seen_err = int'(err);
      end else begin
        @(negedge clk);
      end
    end
    checkOutput({name, "_done_edge"}, seen_at, exp_done);
    checkOutput({name, "_err"}, seen_err, exp_err);
    checkOutput({name, "_pulses"}, pulses, exp_pulses);
    @(negedge clk);
    mode = 0;
  endtask

  initial begin
    int a0, c0, first_acc, waited;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", int'(req_ready), 1);
    checkOutput("reset_en", int'(lat_en), 0);
    checkOutput("reset_s", int'(lat_s), 0);
    checkOutput("reset_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    runDirected("set_ok", 1'b1, 0, 7, 0, 1);
    runDirected("reset_stuck1", 1'b0, 1, CHECKED ? 14 : 7, CHECKED ? 1 : 0, CHECKED ? 2 : 1);
    runDirected("forbidden", 1'b1, 3, CHECKED ? 14 : 7, CHECKED ? 1 : 0, CHECKED ? 2 : 1);
    runDirected("disconnected", 1'b1, 4, CHECKED ? 14 : 7, CHECKED ? 1 : 0, CHECKED ? 2 : 1);
    runDirected("reset_ok", 1'b0, 0, 7, 0, 1);

    // Reset in the middle of the enable pulse
    waitIdle();
    applyStimulus(1'b1, 0, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    a0 = m_acc;
    while (ecount < a0 + 3) @(negedge clk);
    checkOutput("midop_en_before", int'(lat_en), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midop_en_after", int'(lat_en), 0);
    checkOutput("midop_ready", int'(req_ready), 1);
    rst = 1'b0;
    c0 = acc_count;
    applyStimulus(1'b0, 0, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midop_reaccept", acc_count - c0, 1);
    checkOutput("midop_busy", int'(req_ready), 0);

    // Back-to-back with req_valid held high
    waitIdle();
    c0 = acc_count;
    first_acc = -1;
    waited = 0;
    applyStimulus(1'b1, 0, 1'b1);
    while (acc_count < c0 + 2 && waited < 40) begin
      @(negedge clk);
      waited++;
      if (acc_count == c0 + 1 && first_acc < 0) first_acc = m_acc;
    end
    req_valid = 1'b0;
    checkOutput("b2b_gap", (acc_count >= c0 + 2) ? (m_acc - first_acc) : -1, 8);

    // Randomized traffic with occasional resets and latch faults
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (model_idle()) mode = $urandom_range(0, 4);
      req_valid = ($urandom_range(0, 2) == 0);
      req_op    = 1'($urandom);
      rst       = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    waitIdle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles S/R are held stable with enable low before the enable pulse (1..15).
REQ-002 Parameter PULSE_CYC, default 3: width of the enable pulse in cycles (1..15).
REQ-003 Parameter MAX_RETRY, default 1: number of re-drives after a failed readback (0..7).
REQ-004 clk  input  1  the single clock; every flop in the block is updated on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 req_valid  input  1  a write request is present.
REQ-007 req_op  input  1  1 = set latch (Q=1), 0 = reset latch (Q=0).
REQ-008 req_ready  output  1  the block can accept a request this cycle.
REQ-009 lat_s  output  1  set drive to the external enabled SR latch.
REQ-010 lat_r  output  1  reset drive to the external enabled SR latch.
REQ-011 lat_en  output  1  enable (gate) to the external latch.
REQ-012 lat_q, lat_qn  input  1 each  latch outputs, read back.
REQ-013 done  output  1  one-cycle pulse: request finished.
REQ-014 err  output  1  one-cycle pulse, coincident with done: request failed after all retries.

Function
REQ-015 FSM states: IDLE, SETUP, PULSE, HOLD, CHECK; state, lat_s, lat_r, lat_en, done and err are all registered.
REQ-016 req_ready = 1 only in IDLE; a request is accepted on the edge where req_valid & req_ready = 1, and req_op is captured into an op register at that edge.
REQ-017 IDLE -> SETUP on acceptance; lat_s = op, lat_r = ~op, lat_en = 0 for SETUP_CYC cycles.
REQ-018 SETUP -> PULSE; lat_en = 1 for exactly PULSE_CYC cycles, with S/R unchanged.
REQ-019 PULSE -> HOLD for one cycle: lat_en = 0, S/R still held.
REQ-020 HOLD -> CHECK for one cycle: lat_s = lat_r = 0, lat_en = 0; pass when lat_q == op and lat_qn == ~op.
REQ-021 CHECK, pass: done = 1, retry count cleared, next state IDLE.
REQ-022 CHECK, fail with retry count < MAX_RETRY: retry count increments, next state SETUP, done = 0.
REQ-023 CHECK, fail with retry count == MAX_RETRY: done = 1, err = 1, retry count cleared, next state IDLE.
REQ-024 lat_q == lat_qn (the forbidden or metastable latch state) is always a failure.
REQ-025 lat_s & lat_r = 1 never occurs in any cycle.
REQ-026 lat_en = 1 only in PULSE.
REQ-027 Latency with no retry: done is high PULSE_CYC+SETUP_CYC+2 cycles after the acceptance edge; each retry adds SETUP_CYC+PULSE_CYC+2 cycles.
REQ-028 req_valid outside IDLE is ignored and never queued.
REQ-029 A request may be accepted in the cycle immediately after done.

Reset
REQ-030 rst = 1 forces the FSM to IDLE and clears the retry count, the timer and the op register on the next edge, including mid-operation.
REQ-031 While rst = 1 and in the cycle after it: lat_s = lat_r = lat_en = 0, done = err = 0, req_ready = 1.

Configuration
REQ-032 Macro SR_READBACK_CHECK_EN defined: CHECK evaluates lat_q/lat_qn per REQ-020..024.
REQ-033 Macro undefined: CHECK always passes, err is tied 0, lat_q/lat_qn are unused, no retry logic exists, and timing is identical to the pass case.

Structure
REQ-034 Package sr_pkg holds:
- the state enum typedef
- OP_SET = 1 and OP_RESET = 0 constants
- the 4-bit timer width constant
REQ-035 The SETUP and PULSE durations come from one sub-module, sr_pulse_timer: a loadable 4-bit down-counter with a load input and a zero flag.

Verification (SETUP_CYC=2, PULSE_CYC=3, MAX_RETRY=1; T = acceptance edge)
REQ-036 Set request, model latch correct -> lat_en high on edges T+3..T+5; done at T+7; err=0; lat_s=1 through T+6.
REQ-037 Reset request, latch stuck at Q=1 -> retry; done=err=1 at T+14; exactly two enable pulses.
REQ-038 lat_q=lat_qn=1 at CHECK on both attempts -> err=1 with done.
REQ-039 rst asserted at T+4 (mid-PULSE) -> lat_en=0 and req_ready=1 at T+5; new request accepted.
REQ-040 req_valid held high continuously -> back-to-back requests accepted at T and T+8; assertion that lat_s&lat_r is never 1.
REQ-041 Macro undefined, latch disconnected -> done at T+7, err never asserted.
